// File: rtl/opll_pkg.sv
// Shared constants for the OPLL register write path: register map ranges,
// slot/stage timing and the layout of a pending-write entry.
package opll_pkg;

    localparam logic [7:0] CUSTOM_LAST  = 8'h07;
    localparam logic [7:0] RHYTHM_ADDR  = 8'h0E;
    localparam logic [7:0] TEST_ADDR    = 8'h0F;
    localparam logic [7:0] CH_BASE_A    = 8'h10;
    localparam logic [7:0] CH_BASE_B    = 8'h20;
    localparam logic [7:0] CH_BASE_C    = 8'h30;
    localparam int         NUM_CHANNELS = 9;
    localparam int         NUM_SLOTS    = 18;
    localparam logic [1:0] COMMIT_STAGE = 2'd3;
    localparam int         ENTRY_W      = 14;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_entry_t;

    // Only addresses that map onto a real register may be queued.
    function automatic logic addr_valid(input logic [7:0] a);
        logic in_ch;
        in_ch = ((a[7:4] == CH_BASE_A[7:4]) || (a[7:4] == CH_BASE_B[7:4]) ||
                 (a[7:4] == CH_BASE_C[7:4])) && (a[3:0] < 4'(NUM_CHANNELS));
        return (a <= CUSTOM_LAST) || (a == RHYTHM_ADDR) || (a == TEST_ADDR) || in_ch;
    endfunction

endpackage

// File: rtl/opll_wr_fifo.sv
// Synchronous FIFO of pending register writes; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module opll_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/opll_write_sched.sv
// Queues CPU register writes and commits them to the register file only in
// stage-3 windows, never touching a channel while its slot pair is active.
module opll_write_sched
    import opll_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkena,
    input  logic [4:0] slot,
    input  logic [1:0] stage,
    input  logic       cpu_we,
    input  logic       cpu_a0,
    input  logic [7:0] cpu_din,
    output logic       busy,
    output logic       overflow,
    output logic       reg_we,
    output logic [5:0] reg_addr,
    output logic [7:0] reg_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    addr_latch;
    wr_entry_t     push_entry;
    wr_entry_t     head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          pop;
    logic          window;
    logic          head_held;
    logic          full_now;
    logic [4:0]    slot_pair;

    assign push       = cpu_we && cpu_a0 && addr_valid(addr_latch);
    assign push_entry = '{addr: addr_latch[5:0], data: cpu_din};
    assign window     = clkena && (stage == COMMIT_STAGE);
    assign slot_pair  = slot >> 1;
    assign full_now   = (fifo_count == CW'(DEPTH));

    // A channel register is held while its own slot pair is being processed;
    // holding the head also holds everything queued behind it.
    assign head_held = (head.addr >= CH_BASE_A[5:0]) && (slot < 5'(NUM_SLOTS)) &&
                       ({1'b0, head.addr[3:0]} == slot_pair);
    assign pop       = window && !fifo_empty && !head_held;
    assign busy      = fifo_full;

    opll_wr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_latch <= 8'h00;
            overflow   <= 1'b0;
            reg_we     <= 1'b0;
            reg_addr   <= '0;
            reg_data   <= '0;
        end else begin
            if (cpu_we && !cpu_a0) addr_latch <= cpu_din;
            if (push && full_now && !pop) overflow <= 1'b1;
            reg_we <= pop;
            if (pop) begin
                reg_addr <= head.addr;
                reg_data <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_opll_write_sched.sv
// Directed scenarios plus a randomized run of opll_write_sched, checked
// against a queue-based model of the write scheduling rules.
module tb_opll_write_sched;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clkena = 1'b0;
    logic [4:0] slot = '0;
    logic [1:0] stage = '0;
    logic       cpu_we = 1'b0;
    logic       cpu_a0 = 1'b0;
    logic [7:0] cpu_din = '0;
    logic       busy, overflow, reg_we;
    logic [5:0] reg_addr;
    logic [7:0] reg_data;

    int total = 0;
    int bad = 0;

    logic [13:0] m_q[$];
    logic [7:0]  m_latch;
    logic        m_overflow, m_reg_we, m_busy;
    logic [5:0]  m_reg_addr;
    logic [7:0]  m_reg_data;

    opll_write_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clkena(clkena), .slot(slot), .stage(stage),
        .cpu_we(cpu_we), .cpu_a0(cpu_a0), .cpu_din(cpu_din), .busy(busy),
        .overflow(overflow), .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data)
    );

    always #5 clk = ~clk;

    function automatic bit valid_addr(input int a);
        return (a <= 7) || (a == 14) || (a == 15) || (a >= 16 && a <= 24) ||
               (a >= 32 && a <= 40) || (a >= 48 && a <= 56);
    endfunction

    // Reference model: advance one clock given the inputs now on the pins.
    task automatic model_step();
        logic [13:0] h;
        bit pop_now;
        int ha;
        if (reset) begin
            m_q.delete();
            m_latch = 8'h00; m_overflow = 0; m_reg_we = 0; m_reg_addr = 0; m_reg_data = 0;
        end else begin
            pop_now = 0;
            if (clkena && stage == 3 && m_q.size() > 0) begin
                ha = int'(m_q[0][13:8]);
                pop_now = !(ha >= 16 && (ha % 16) == int'(slot) / 2);
            end
            m_reg_we = pop_now;
            if (pop_now) begin
                h = m_q.pop_front();
                m_reg_addr = h[13:8];
                m_reg_data = h[7:0];
            end
            if (cpu_we && cpu_a0 && valid_addr(int'(m_latch))) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_latch[5:0], cpu_din});
                else m_overflow = 1;
            end
            if (cpu_we && !cpu_a0) m_latch = cpu_din;
        end
        m_busy = (m_q.size() == DEPTH);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        cpu_we = 1; cpu_a0 = a0; cpu_din = d;
        cycle();
        cpu_we = 0;
    endtask

    task automatic commit_window(input logic [4:0] s);
        clkena = 1; stage = 3; slot = s;
        cycle();
        clkena = 0; stage = 0;
    endtask

    task automatic do_reset();
        reset = 1; cycle(); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; cycle(); cycle();
        total++;
        if ({reg_we, reg_addr, reg_data, busy, overflow} !== 17'h0) begin
            bad++; $display("[TB] FAIL reset_state got=%h exp=0", {reg_we, reg_addr, reg_data, busy, overflow});
        end
        reset = 0;
    endtask

    task automatic test_basic();
        slot = 5;
        wr(0, 8'h10); wr(1, 8'h5A); cycle();
        total++;
        if (reg_we !== 1'b0) begin bad++; $display("[TB] FAIL basic_early got=%b exp=0", reg_we); end
        commit_window(5);
        total++;
        if ({reg_we, reg_addr, reg_data} !== {1'b1, 6'h10, 8'h5A}) begin
            bad++; $display("[TB] FAIL basic_commit got=%h exp=%h", {reg_we, reg_addr, reg_data}, {1'b1, 6'h10, 8'h5A});
        end
        cycle();
        total++;
        if (reg_we !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse got=%b exp=0", reg_we); end
        commit_window(5);
        total++;
        if (reg_we !== 1'b0) begin bad++; $display("[TB] FAIL basic_single got=%b exp=0", reg_we); end
    endtask

    task automatic test_channel_hold();
        slot = 2;
        wr(0, 8'h21); wr(1, 8'h33);
        commit_window(2);
        total++;
        if (reg_we !== 1'b0) begin bad++; $display("[TB] FAIL hold_slot2 got=%b exp=0", reg_we); end
        commit_window(3);
        total++;
        if (reg_we !== 1'b0) begin bad++; $display("[TB] FAIL hold_slot3 got=%b exp=0", reg_we); end
        commit_window(4);
        total++;
        if ({reg_we, reg_addr, reg_data} !== {1'b1, 6'h21, 8'h33}) begin
            bad++; $display("[TB] FAIL hold_release got=%h exp=%h", {reg_we, reg_addr, reg_data}, {1'b1, 6'h21, 8'h33});
        end
    endtask

    task automatic test_overflow();
        logic [14:0] exp;
        for (int i = 0; i < 5; i++) begin
            wr(0, 8'(i)); wr(1, 8'(8'hA0 + i));
            if (i == 2 || i == 3) begin
                total++;
                if ({busy, overflow} !== {(i == 3), 1'b0}) begin
                    bad++; $display("[TB] FAIL ovf_fill%0d got=%b%b exp=%b0", i, busy, overflow, (i == 3));
                end
            end
        end
        total++;
        if ({busy, overflow} !== 2'b11) begin bad++; $display("[TB] FAIL ovf_flag got=%b%b exp=11", busy, overflow); end
        for (int i = 0; i < 4; i++) begin
            commit_window(0);
            exp = {1'b1, 6'(i), 8'(8'hA0 + i)};
            total++;
            if ({reg_we, reg_addr, reg_data} !== exp) begin
                bad++; $display("[TB] FAIL ovf_drain%0d got=%h exp=%h", i, {reg_we, reg_addr, reg_data}, exp);
            end
        end
        commit_window(0);
        total++;
        if ({reg_we, busy, overflow} !== 3'b001) begin
            bad++; $display("[TB] FAIL ovf_after got=%b exp=001", {reg_we, busy, overflow});
        end
    endtask

    task automatic test_invalid();
        do_reset();
        wr(0, 8'h09); wr(1, 8'h77);
        commit_window(0);
        total++;
        if ({reg_we, busy, overflow} !== 3'b000) begin
            bad++; $display("[TB] FAIL invalid_drop got=%b exp=000", {reg_we, busy, overflow});
        end
        wr(0, 8'h0E); wr(1, 8'h20);
        commit_window(0);
        total++;
        if ({reg_we, reg_addr, reg_data} !== {1'b1, 6'h0E, 8'h20}) begin
            bad++; $display("[TB] FAIL rhythm_commit got=%h exp=%h", {reg_we, reg_addr, reg_data}, {1'b1, 6'h0E, 8'h20});
        end
        wr(1, 8'h21);
        commit_window(0);
        total++;
        if ({reg_we, reg_addr, reg_data} !== {1'b1, 6'h0E, 8'h21}) begin
            bad++; $display("[TB] FAIL latch_persist got=%h exp=%h", {reg_we, reg_addr, reg_data}, {1'b1, 6'h0E, 8'h21});
        end
    endtask

    task automatic test_full_window();
        logic [14:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin wr(0, 8'(i)); wr(1, 8'(8'hB0 + i)); end
        clkena = 1; stage = 3; slot = 0; cpu_we = 1; cpu_a0 = 1; cpu_din = 8'hB4;
        cycle();
        clkena = 0; stage = 0; cpu_we = 0;
        total++;
        if ({reg_we, reg_addr, reg_data, busy, overflow} !== {1'b1, 6'h00, 8'hB0, 1'b1, 1'b0}) begin
            bad++; $display("[TB] FAIL full_window got=%h exp=%h", {reg_we, reg_addr, reg_data, busy, overflow}, {1'b1, 6'h00, 8'hB0, 1'b1, 1'b0});
        end
        for (int i = 1; i < 5; i++) begin
            commit_window(0);
            exp = {1'b1, 6'((i < 4) ? i : 3), 8'(8'hB0 + i)};
            total++;
            if ({reg_we, reg_addr, reg_data} !== exp) begin
                bad++; $display("[TB] FAIL full_drain%0d got=%h exp=%h", i, {reg_we, reg_addr, reg_data}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin wr(0, 8'(i)); wr(1, 8'(8'hC0 + i)); end
        wr(1, 8'hC4);
        commit_window(0);
        total++;
        if ({reg_we, reg_addr, reg_data, overflow} !== {1'b1, 6'h00, 8'hC0, 1'b1}) begin
            bad++; $display("[TB] FAIL mid_setup got=%h exp=%h", {reg_we, reg_addr, reg_data, overflow}, {1'b1, 6'h00, 8'hC0, 1'b1});
        end
        reset = 1; clkena = 1; stage = 3;
        cycle();
        reset = 0; clkena = 0; stage = 0;
        total++;
        if ({reg_we, busy, overflow} !== 3'b000) begin
            bad++; $display("[TB] FAIL mid_reset got=%b exp=000", {reg_we, busy, overflow});
        end
        wr(0, 8'h05); wr(1, 8'hD5);
        commit_window(0);
        total++;
        if ({reg_we, reg_addr, reg_data} !== {1'b1, 6'h05, 8'hD5}) begin
            bad++; $display("[TB] FAIL mid_after got=%h exp=%h", {reg_we, reg_addr, reg_data}, {1'b1, 6'h05, 8'hD5});
        end
        for (int i = 0; i < 4; i++) begin
            commit_window(0);
            total++;
            if ({reg_we, busy, overflow} !== 3'b000) begin
                bad++; $display("[TB] FAIL mid_stale%0d got=%b exp=000", i, {reg_we, busy, overflow});
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] exp;
        slot = 0; stage = 0;
        for (int n = 0; n < 3000; n++) begin
            clkena = 1'($urandom_range(0, 1));
            reset  = ($urandom_range(0, 399) == 0);
            cpu_we = ($urandom_range(0, 3) == 0);
            cpu_a0 = 1'($urandom_range(0, 1));
            if (!cpu_a0) begin
                case ($urandom_range(0, 3))
                    0: cpu_din = 8'($urandom_range(0, 255));
                    1: cpu_din = 8'(16 * $urandom_range(1, 3) + $urandom_range(0, 8));
                    2: cpu_din = 8'($urandom_range(0, 7));
                    default: cpu_din = 8'($urandom_range(14, 15));
                endcase
            end else begin
                cpu_din = 8'($urandom_range(0, 255));
            end
            cycle();
            exp = {m_reg_we, m_reg_addr, m_reg_data, m_busy, m_overflow};
            total++;
            if ({reg_we, reg_addr, reg_data, busy, overflow} !== exp) begin
                bad++; $display("[TB] FAIL random%0d got=%h exp=%h", n, {reg_we, reg_addr, reg_data, busy, overflow}, exp);
            end
            if (clkena) begin
                if (stage == 3) slot = (slot == 17) ? 5'd0 : slot + 5'd1;
                stage = stage + 2'd1;
            end
        end
        reset = 0; cpu_we = 0; clkena = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_channel_hold();
        test_overflow();
        test_invalid();
        test_full_window();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
